vsync_phase_detect: RTL
=======================

Name: vsync_phase_detect

Overview:
- Measures the frame-start phase offset between the two camera channels.
- Compares rising vsync edges of sensor 0 and sensor 1.
- Drives err_ch0/err_ch1 into the downstream 24 MHz sensor-clock trimmer. An asserted err_chN makes that stage speed up channel N's sensor clock until the frames realign.
- Sits between the camera capture front-ends and the sensor-clock generator, in the system clk domain.

Parameters:
- CNT_W, 24, width of the phase counter and of phase_delta
- TOL_HI, 16, offset in clk cycles above which an error is asserted
- TOL_LO, 4, offset at or below which an asserted error is released; must be < TOL_HI
- MAX_WIN, 1000000, maximum cycles to wait for the second vsync edge before discarding the measurement; must be < 2^CNT_W
- LOCK_CNT, 4, consecutive in-tolerance measurements required to assert locked

Ports:
- clk  in  1  system clock; same clock as the sensor-clock generator
- reset  in  1  synchronous, active-high reset
- vsync_0  in  1  channel 0 frame sync, asynchronous to clk
- vsync_1  in  1  channel 1 frame sync, asynchronous to clk
- err_ch0  out  1  channel 0 lags; speed up channel 0
- err_ch1  out  1  channel 1 lags; speed up channel 1
- phase_delta  out  CNT_W  magnitude of the last valid measured offset, in clk cycles
- delta_valid  out  1  one-cycle pulse when phase_delta updates
- locked  out  1  LOCK_CNT consecutive measurements with offset <= TOL_LO

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. On reset, every output is 0 and the FSM enters IDLE. Reset asserted mid-measurement aborts the measurement with no delta_valid pulse.
- Input synchronisation:
  - Each vsync passes through a 2-FF synchronizer, then an edge register.
  - A rising-edge pulse appears 3 clk cycles after the input transition.
  - Both channels have identical latency, so the measured offset is unbiased.
- FSM states: IDLE, WAIT_0, WAIT_1, EVAL.
- IDLE:
  - rise_0 alone → WAIT_1, cnt = 1.
  - rise_1 alone → WAIT_0, cnt = 1.
  - Both in the same cycle → EVAL, delta = 0, leader = none.
- WAIT_1 (channel 0 led):
  - rise_1 → EVAL, delta = cnt, lagging channel = 1. Otherwise cnt increments.
  - A second rise_0 restarts the measurement: cnt = 1, stay in WAIT_1.
  - cnt == MAX_WIN → IDLE, discard, locked cleared, err outputs unchanged.
- WAIT_0: mirror of WAIT_1 with channels swapped.
- EVAL (one cycle):
  - Latch phase_delta = delta and pulse delta_valid.
  - Update the error and lock logic, then return to IDLE.
  - An edge arriving while in EVAL is lost. This is acceptable: frame periods are far longer than 1 cycle.
- Error logic (hysteresis), evaluated in EVAL:
  - delta > TOL_HI and channel 1 lags → err_ch1 = 1, err_ch0 = 0.
  - delta > TOL_HI and channel 0 lags → err_ch0 = 1, err_ch1 = 0.
  - delta <= TOL_LO → both errors cleared.
  - TOL_LO < delta <= TOL_HI → errors hold previous values, except an asserted error for the channel that now leads is cleared.
  - err_ch0 and err_ch1 are never both 1.
  - Errors change only in the cycle after EVAL, i.e. registered outputs.
- Lock logic:
  - lock_cnt increments on an EVAL with delta <= TOL_LO, saturating at LOCK_CNT.
  - It clears on any EVAL with delta > TOL_LO, or on a timeout.
  - locked = (lock_cnt == LOCK_CNT).
- Width rule: cnt saturates at MAX_WIN and never wraps. phase_delta is unsigned magnitude; direction is carried only by err_ch0/err_ch1.

Decomposition:
- Shared camera-sync package holds:
  - FSM state enum (IDLE, WAIT_0, WAIT_1, EVAL)
  - default CNT_W
  - lag-direction encoding (NONE, CH0, CH1), reused by the sensor-clock generator testbench
- One sub-module, sync_rise_det: 2-FF synchronizer plus rising-edge pulse, instantiated once per channel.

Test Plan (use TOL_HI = 16, TOL_LO = 4, MAX_WIN = 1000, LOCK_CNT = 4 where not stated):
- vsync_0 rises 40 cycles before vsync_1 → delta_valid pulse, phase_delta = 40, err_ch1 = 1, err_ch0 = 0, locked = 0.
- vsync_1 rises 25 cycles before vsync_0 → phase_delta = 25, err_ch0 = 1. Next frames at offsets 10 then 3 → err_ch0 stays 1 after the first, falls to 0 after the second.
- Both vsyncs rise in the same cycle, four frames → phase_delta = 0 each frame, locked = 1 after the 4th delta_valid. A fifth frame at offset 20 → locked = 0 and the err for the lagging channel set.
- vsync_0 rises and vsync_1 stays low for 1200 cycles → no delta_valid, FSM back in IDLE at cycle 1000, locked cleared, err outputs unchanged.
- reset asserted 50 cycles into WAIT_1 → all outputs 0 next cycle, no delta_valid. A subsequent pair of edges at offset 7 → phase_delta = 7, no err asserted.
- Channel 0 lags by 30 (err_ch0 = 1), then next frame channel 1 lags by 10 → err_ch0 cleared, err_ch1 remains 0.

Source files
------------

// File: rtl/vsync_phase_detect_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vsync_phase_detect_pkg
// Brief    : Shared camera-sync types: measurement FSM states, lag direction
// Revision : 1.0
// ============================================================================
package vsync_phase_detect_pkg;

  localparam int c_default_cnt_w = 24;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT_0 = 2'd1,
    ST_WAIT_1 = 2'd2,
    ST_EVAL   = 2'd3
  } state_t;

  // Which channel's frame arrived late; shared with the sensor-clock generator.
  typedef enum logic [1:0] {
    LAG_NONE = 2'd0,
    LAG_CH0  = 2'd1,
    LAG_CH1  = 2'd2
  } lag_t;

endpackage
`default_nettype wire

// File: rtl/vsync_phase_detect_sync_rise_det.sv
`default_nettype none
// ============================================================================
// Module   : sync_rise_det
// Brief    : 2-FF synchronizer plus registered rising-edge pulse (3-cycle lat.)
// Revision : 1.0
// ============================================================================
module sync_rise_det (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;
  logic r_rise;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
      r_rise <= r_sync & ~r_prev;
    end
  end

  assign o_rise = r_rise;

endmodule
`default_nettype wire

// File: rtl/vsync_phase_detect.sv
`default_nettype none
// ============================================================================
// Module   : vsync_phase_detect
// Brief    : Measures vsync rise offset between two cameras; drives trim errors
// Revision : 1.0
// ============================================================================
module vsync_phase_detect
  import vsync_phase_detect_pkg::*;
#(
  parameter int CNT_W    = c_default_cnt_w,
  parameter int TOL_HI   = 16,
  parameter int TOL_LO   = 4,
  parameter int MAX_WIN  = 1000000,
  parameter int LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             vsync_0,
  input  logic             vsync_1,
  output logic             err_ch0,
  output logic             err_ch1,
  output logic [CNT_W-1:0] phase_delta,
  output logic             delta_valid,
  output logic             locked
);

  localparam int                c_lk_w    = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0]  c_tol_hi  = CNT_W'(TOL_HI);
  localparam logic [CNT_W-1:0]  c_tol_lo  = CNT_W'(TOL_LO);
  localparam logic [CNT_W-1:0]  c_max_win = CNT_W'(MAX_WIN);
  localparam logic [c_lk_w-1:0] c_lock    = c_lk_w'(LOCK_CNT);

  logic              w_rise_0, w_rise_1;
  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0]  r_delta, w_delta_nxt;
  lag_t              r_lag, w_lag_nxt;
  logic              w_timeout;
  logic [c_lk_w-1:0] r_lock_cnt, w_lock_cnt_nxt;
  logic              r_err0, r_err1, w_err0_nxt, w_err1_nxt;
  logic [CNT_W-1:0]  r_phase;
  logic              r_valid, r_locked;

  sync_rise_det u_rise_0 (.clk(clk), .reset(reset), .i_async(vsync_0), .o_rise(w_rise_0));
  sync_rise_det u_rise_1 (.clk(clk), .reset(reset), .i_async(vsync_1), .o_rise(w_rise_1));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_delta_nxt = r_delta;
    w_lag_nxt   = r_lag;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rise_0 && w_rise_1) begin
          w_state_nxt = ST_EVAL;
          w_delta_nxt = '0;
          w_lag_nxt   = LAG_NONE;
        end else if (w_rise_0) begin
          w_state_nxt = ST_WAIT_1;
          w_cnt_nxt   = CNT_W'(1);
        end else if (w_rise_1) begin
          w_state_nxt = ST_WAIT_0;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      // A completing edge wins over a same-cycle restart of the leader.
      ST_WAIT_1: begin
        if (w_rise_1) begin
          w_state_nxt = ST_EVAL;
          w_delta_nxt = r_cnt;
          w_lag_nxt   = LAG_CH1;
        end else if (w_rise_0) begin
          w_cnt_nxt = CNT_W'(1);
        end else if (r_cnt == c_max_win) begin
          w_state_nxt = ST_IDLE;
          w_timeout   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_WAIT_0: begin
        if (w_rise_0) begin
          w_state_nxt = ST_EVAL;
          w_delta_nxt = r_cnt;
          w_lag_nxt   = LAG_CH0;
        end else if (w_rise_1) begin
          w_cnt_nxt = CNT_W'(1);
        end else if (r_cnt == c_max_win) begin
          w_state_nxt = ST_IDLE;
          w_timeout   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_EVAL: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_err0_nxt     = r_err0;
    w_err1_nxt     = r_err1;
    w_lock_cnt_nxt = r_lock_cnt;
    if (r_state == ST_EVAL) begin
      if (r_delta > c_tol_hi) begin
        w_err0_nxt = (r_lag == LAG_CH0);
        w_err1_nxt = (r_lag == LAG_CH1);
      end else if (r_delta <= c_tol_lo) begin
        w_err0_nxt = 1'b0;
        w_err1_nxt = 1'b0;
      end else begin
        // Inside the hysteresis band only the now-leading channel's error drops.
        if (r_lag == LAG_CH1) w_err0_nxt = 1'b0;
        if (r_lag == LAG_CH0) w_err1_nxt = 1'b0;
      end
      if (r_delta <= c_tol_lo) begin
        if (r_lock_cnt != c_lock) w_lock_cnt_nxt = r_lock_cnt + 1'b1;
      end else begin
        w_lock_cnt_nxt = '0;
      end
    end else if (w_timeout) begin
      w_lock_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_delta    <= '0;
      r_lag      <= LAG_NONE;
      r_lock_cnt <= '0;
      r_err0     <= 1'b0;
      r_err1     <= 1'b0;
      r_phase    <= '0;
      r_valid    <= 1'b0;
      r_locked   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_delta    <= w_delta_nxt;
      r_lag      <= w_lag_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
      r_err0     <= w_err0_nxt;
      r_err1     <= w_err1_nxt;
      r_valid    <= (r_state == ST_EVAL);
      r_locked   <= (w_lock_cnt_nxt == c_lock);
      if (r_state == ST_EVAL) r_phase <= r_delta;
    end
  end

  assign err_ch0     = r_err0;
  assign err_ch1     = r_err1;
  assign phase_delta = r_phase;
  assign delta_valid = r_valid;
  assign locked      = r_locked;

endmodule
`default_nettype wire
